// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NUM_REQ requesters
// and returns each result, tagged with the requester index, on a response channel.
package alu_arbiter_pkg;
  localparam int FN_W = 3;
  localparam int F7_W = 7;

  typedef enum logic [FN_W-1:0] {
    ADD_SUB = 3'd0,
    SLL     = 3'd1,
    SLT     = 3'd2,
    SLTU    = 3'd3,
    XOR     = 3'd4,
    SRL_SRA = 3'd5,
    OR      = 3'd6,
    AND     = 3'd7
  } alu_fn_t;

  typedef enum logic [F7_W-1:0] {
    ADD_SRL = 7'h00,
    SUB_SRA = 7'h20
  } funct7_t;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*FN_W-1:0]  req_fn,
  input  logic [NUM_REQ*F7_W-1:0]  req_funct7,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [FN_W-1:0]          alu_fn,
  output logic [F7_W-1:0]          alu_funct7,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic [WIDTH-1:0]         alu_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                 state, state_next;
  logic [ID_W-1:0]        rr_ptr, grant, rr_next;
  logic                   grant_found, accept;
  logic [2*NUM_REQ-1:0]   rotated;
  int                     pos;
  logic [FN_W-1:0]        sel_fn;
  logic [F7_W-1:0]        sel_funct7;
  logic [WIDTH-1:0]       sel_a, sel_b;

  // Rotate the valid vector so bit 0 is the requester at rr_ptr, then take the first set bit.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    pos         = 0;
    rotated     = {req_valid, req_valid} >> rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && rotated[k]) begin
        grant_found = 1'b1;
        pos = int'(rr_ptr) + k;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        grant = ID_W'(pos);
      end
    end
  end

  always_comb begin
    sel_fn     = '0;
    sel_funct7 = '0;
    sel_a      = '0;
    sel_b      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_fn     = req_fn[i*FN_W +: FN_W];
        sel_funct7 = req_funct7[i*F7_W +: F7_W];
        sel_a      = req_a[i*WIDTH +: WIDTH];
        sel_b      = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rr_next = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
  assign accept  = |req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Grants are only offered in IDLE and never while reset is asserted.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_found && rst_n) begin
          req_ready[grant] = 1'b1;
          state_next       = EXEC;
        end
      end
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      alu_fn     <= ADD_SUB;
      alu_funct7 <= ADD_SRL;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      if (accept) begin
        alu_fn     <= sel_fn;
        alu_funct7 <= sel_funct7;
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        rsp_id     <= grant;
        rr_ptr     <= rr_next;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_out;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a small ALU model closes the loop, and each step
// compares outputs against hand-computed values with immediate assertions.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*FN_W-1:0]  req_fn;
  logic [NUM_REQ*F7_W-1:0]  req_funct7;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [FN_W-1:0]          alu_fn;
  logic [F7_W-1:0]          alu_funct7;
  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic [WIDTH-1:0]         alu_out;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [0:0]               rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fn(req_fn), .req_funct7(req_funct7), .req_a(req_a), .req_b(req_b),
    .alu_fn(alu_fn), .alu_funct7(alu_funct7), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  // Stand-in for the shared combinational ALU.
  always_comb begin
    alu_out = '0;
    case (alu_fn)
      ADD_SUB: alu_out = (alu_funct7 == SUB_SRA) ? alu_a - alu_b : alu_a + alu_b;
      SLL:     alu_out = alu_a << alu_b[4:0];
      SLT:     alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
      SLTU:    alu_out = {31'b0, alu_a < alu_b};
      XOR:     alu_out = alu_a ^ alu_b;
      SRL_SRA: alu_out = (alu_funct7 == SUB_SRA) ? WIDTH'($signed(alu_a) >>> alu_b[4:0])
                                                 : alu_a >> alu_b[4:0];
      OR:      alu_out = alu_a | alu_b;
      AND:     alu_out = alu_a & alu_b;
      default: alu_out = '0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [FN_W-1:0] fn,
                               input logic [F7_W-1:0] f7, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    if (r == 0) begin
      req_fn[FN_W-1:0]     = fn;
      req_funct7[F7_W-1:0] = f7;
      req_a[WIDTH-1:0]     = a;
      req_b[WIDTH-1:0]     = b;
    end else begin
      req_fn[2*FN_W-1:FN_W]     = fn;
      req_funct7[2*F7_W-1:F7_W] = f7;
      req_a[2*WIDTH-1:WIDTH]    = a;
      req_b[2*WIDTH-1:WIDTH]    = b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    rsp_ready  = 1'b0;
    req_fn     = '0;
    req_funct7 = '0;
    req_a      = '0;
    req_b      = '0;

    // Reset held for two edges with both requesters asking
    tick();
    tick();
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rsp_id", 64'(rsp_id), 64'd0);
    checkOutput("rst_rsp_data", 64'(rsp_data), 64'd0);
    checkOutput("rst_alu_a", 64'(alu_a), 64'd0);
    checkOutput("rst_alu_b", 64'(alu_b), 64'd0);
    checkOutput("rst_alu_fn", 64'(alu_fn), 64'(ADD_SUB));
    checkOutput("rst_alu_funct7", 64'(alu_funct7), 64'(ADD_SRL));

    // Requester 0 alone: 5 + 6
    req_valid = 2'b00;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(0, ADD_SUB, ADD_SRL, 32'd5, 32'd6);
    req_valid = 2'b01;
    #1;
    checkOutput("t2_req_ready", 64'(req_ready), 64'b01);
    checkOutput("t2_busy_idle", 64'(busy), 64'd0);
    tick();
    req_valid = 2'b00;
    checkOutput("t2_alu_a", 64'(alu_a), 64'd5);
    checkOutput("t2_alu_b", 64'(alu_b), 64'd6);
    checkOutput("t2_busy_exec", 64'(busy), 64'd1);
    checkOutput("t2_no_early_rsp", 64'(rsp_valid), 64'd0);
    checkOutput("t2_ready_exec", 64'(req_ready), 64'd0);
    tick();
    checkOutput("t2_rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("t2_rsp_data", 64'(rsp_data), 64'h0000000B);
    checkOutput("t2_rsp_id", 64'(rsp_id), 64'd0);
    tick();
    checkOutput("t2_rsp_done", 64'(rsp_valid), 64'd0);
    checkOutput("t2_alu_a_kept", 64'(alu_a), 64'd5);

    // Requester 1 alone: 5 - (-6), then -1 + 1
    applyStimulus(1, ADD_SUB, SUB_SRA, 32'd5, 32'hFFFFFFFA);
    req_valid = 2'b10;
    #1;
    checkOutput("t3_req_ready", 64'(req_ready), 64'b10);
    tick();
    req_valid = 2'b00;
    checkOutput("t3_alu_funct7", 64'(alu_funct7), 64'(SUB_SRA));
    tick();
    checkOutput("t3_rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("t3_rsp_data", 64'(rsp_data), 64'h0000000B);
    checkOutput("t3_rsp_id", 64'(rsp_id), 64'd1);
    tick();
    applyStimulus(1, ADD_SUB, ADD_SRL, 32'hFFFFFFFF, 32'd1);
    req_valid = 2'b10;
    #1;
    checkOutput("t3b_req_ready", 64'(req_ready), 64'b10);
    tick();
    req_valid = 2'b00;
    tick();
    checkOutput("t3b_rsp_data", 64'(rsp_data), 64'd0);
    checkOutput("t3b_rsp_id", 64'(rsp_id), 64'd1);
    tick();

    // Both requesters continuously valid: grants alternate 0,1,0,1 every 3 cycles
    applyStimulus(0, ADD_SUB, ADD_SRL, 32'd10, 32'd1);
    applyStimulus(1, ADD_SUB, SUB_SRA, 32'd100, 32'd1);
    req_valid = 2'b11;
    for (int op = 0; op < 4; op++) begin
      #1;
      checkOutput("t4_busy_idle", 64'(busy), 64'd0);
      checkOutput("t4_req_ready", 64'(req_ready), (op % 2 == 1) ? 64'b10 : 64'b01);
      tick();
      tick();
      checkOutput("t4_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("t4_rsp_id", 64'(rsp_id), 64'(op % 2));
      checkOutput("t4_rsp_data", 64'(rsp_data), (op % 2 == 1) ? 64'd99 : 64'd11);
      tick();
    end

    // Response stall with both requesters still valid
    rsp_ready = 1'b0;
    #1;
    checkOutput("t5_req_ready", 64'(req_ready), 64'b01);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("t5_hold_valid", 64'(rsp_valid), 64'd1);
      checkOutput("t5_hold_id", 64'(rsp_id), 64'd0);
      checkOutput("t5_hold_data", 64'(rsp_data), 64'd11);
      checkOutput("t5_hold_ready", 64'(req_ready), 64'd0);
      checkOutput("t5_hold_busy", 64'(busy), 64'd1);
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput("t5_release_valid", 64'(rsp_valid), 64'd0);
    checkOutput("t5_release_busy", 64'(busy), 64'd0);
    #1;
    checkOutput("t5_next_grant", 64'(req_ready), 64'b10);

    // Reset during EXEC: pointer sits at 1 before reset, must come back as 0
    req_valid = 2'b01;
    #1;
    checkOutput("t6_req_ready", 64'(req_ready), 64'b01);
    tick();
    checkOutput("t6_busy_exec", 64'(busy), 64'd1);
    rst_n     = 1'b0;
    req_valid = 2'b11;
    tick();
    checkOutput("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("t6_rst_busy", 64'(busy), 64'd0);
    #1;
    checkOutput("t6_rst_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("t6_grant_req0", 64'(req_ready), 64'b01);
    tick();
    checkOutput("t6_no_pulse", 64'(rsp_valid), 64'd0);
    tick();
    checkOutput("t6_rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("t6_rsp_id", 64'(rsp_id), 64'd0);
    req_valid = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
